// File: rtl/branch_sequencer_if.sv
// Branch request bus between decode (master) and branch_sequencer (slave).
interface branch_sequencer_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFF_W  = 16;
   localparam int unsigned OP_W   = 3;

   logic              br_valid;
   logic              br_ready;
   logic [OP_W-1:0]   br_op;
   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic [OFF_W-1:0]  offset;
   logic [DATA_W-1:0] br_pc;
   logic              br_done;
   logic              br_taken;

   modport master (
      output br_valid, br_op, rs, rt, offset, br_pc,
      input  br_ready, br_done, br_taken
   );

   modport slave (
      input  br_valid, br_op, rs, rt, offset, br_pc,
      output br_ready, br_done, br_taken
   );
endinterface

// File: rtl/branch_sequencer.sv
// Next-PC controller: owns the fetch PC, accepts one branch/jump request at a
// time, resolves it over RUN -> EVAL -> RESOLVE and redirects with a flush
// pulse on a wrong fetch path.
// Optional feature macro: BRANCH_PREDICT_EN enables static backward-taken /
// forward-not-taken prediction with a speculative PC load at accept.
module branch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_stall,
   branch_sequencer_if.slave  br,
   output logic [31:0]        pc,
   output logic               flush
);
   localparam int unsigned PC_W  = 32;
   localparam int unsigned OFF_W = 16;
   localparam int unsigned OP_W  = 3;

   localparam logic [OP_W-1:0] OP_BEQ  = 3'b000;
   localparam logic [OP_W-1:0] OP_BNE  = 3'b001;
   localparam logic [OP_W-1:0] OP_BLT  = 3'b010;
   localparam logic [OP_W-1:0] OP_BGTE = 3'b011;
   localparam logic [OP_W-1:0] OP_BLTU = 3'b100;
   localparam logic [OP_W-1:0] OP_BGEU = 3'b101;
   localparam logic [OP_W-1:0] OP_J    = 3'b110;

   typedef enum logic [1:0] {RUN, EVAL, RESOLVE} state_t;

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [PC_W-1:0]   rs_q;
   logic [PC_W-1:0]   rt_q;
   logic [OFF_W-1:0]  offset_q;
   logic [PC_W-1:0]   br_pc_q;
   logic              pred_q;

   logic              cond_c;
   logic              pred_in_c;
   logic [PC_W-1:0]   pc_seq_c;
   logic [PC_W-1:0]   accept_pc_c;
   logic [PC_W-1:0]   target_c;
   logic [PC_W-1:0]   fall_thru_c;

   // Sequential advance honouring fetch_stall.
   assign pc_seq_c = fetch_stall ? pc : pc + PC_W'(4);

   // Resolution targets from the captured request; arithmetic wraps mod 2^32.
   assign fall_thru_c = br_pc_q + PC_W'(4);
   assign target_c    = fall_thru_c + {{(PC_W-OFF_W-2){offset_q[OFF_W-1]}}, offset_q, 2'b00};

`ifdef BRANCH_PREDICT_EN
   logic [PC_W-1:0] accept_target_c;

   // Backward conditional branches and jumps are predicted taken and fetched speculatively.
   assign accept_target_c = br.br_pc + PC_W'(4)
                          + {{(PC_W-OFF_W-2){br.offset[OFF_W-1]}}, br.offset, 2'b00};
   assign pred_in_c   = (br.br_op == OP_J) || ((br.br_op <= OP_BGEU) && br.offset[OFF_W-1]);
   assign accept_pc_c = pred_in_c ? accept_target_c : pc_seq_c;
`else
   // No prediction: fetch always falls through until resolution.
   assign pred_in_c   = 1'b0;
   assign accept_pc_c = pc_seq_c;
`endif

   // Branch condition on captured operands; reserved op is never taken.
   always_comb begin
      cond_c = 1'b0;
      case (op_q)
         OP_BEQ:  cond_c = (rs_q == rt_q);
         OP_BNE:  cond_c = (rs_q != rt_q);
         OP_BLT:  cond_c = ($signed(rs_q) <  $signed(rt_q));
         OP_BGTE: cond_c = ($signed(rs_q) >= $signed(rt_q));
         OP_BLTU: cond_c = (rs_q <  rt_q);
         OP_BGEU: cond_c = (rs_q >= rt_q);
         OP_J:    cond_c = 1'b1;
         default: cond_c = 1'b0;
      endcase
   end

   // Sequencer FSM with registered PC, handshake and resolution outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         flush       <= 1'b0;
         br.br_ready <= 1'b1;
         br.br_done  <= 1'b0;
         br.br_taken <= 1'b0;
         op_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         offset_q    <= '0;
         br_pc_q     <= '0;
         pred_q      <= 1'b0;
      end else begin
         flush       <= 1'b0;
         br.br_done  <= 1'b0;
         br.br_taken <= 1'b0;
         case (state)
            RUN: begin
               if (br.br_valid) begin
                  op_q        <= br.br_op;
                  rs_q        <= br.rs;
                  rt_q        <= br.rt;
                  offset_q    <= br.offset;
                  br_pc_q     <= br.br_pc;
                  pred_q      <= pred_in_c;
                  pc          <= accept_pc_c;
                  br.br_ready <= 1'b0;
                  state       <= EVAL;
               end else begin
                  pc <= pc_seq_c;
               end
            end
            EVAL: begin
               br.br_done  <= 1'b1;
               br.br_taken <= cond_c;
               if (cond_c != pred_q) begin
                  flush <= 1'b1;
                  pc    <= cond_c ? target_c : fall_thru_c;
               end else begin
                  pc <= pc_seq_c;
               end
               state <= RESOLVE;
            end
            RESOLVE: begin
               pc          <= pc_seq_c;
               br.br_ready <= 1'b1;
               state       <= RUN;
            end
            default: begin
               br.br_ready <= 1'b1;
               state       <= RUN;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed cases plus randomized requests against
// a transaction-level reference model of the fetch PC and resolution.
module tb_branch_sequencer;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_stall = 1'b0;
   logic [31:0] pc;
   logic        flush;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_pc;

   branch_sequencer_if bif ();

   branch_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_stall (fetch_stall),
      .br          (bif),
      .pc          (pc),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] adv(input logic st);
      return st ? exp_pc : exp_pc + 32'd4;
   endfunction

   // Reference condition: signed order via sign-bit bias into unsigned order.
   function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ab;
      logic [31:0] bb;
      ab = a ^ 32'h8000_0000;
      bb = b ^ 32'h8000_0000;
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return ab < bb;
         3'd3:    return !(ab < bb);
         3'd4:    return a < b;
         3'd5:    return !(a < b);
         3'd6:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic ref_pred(input logic [2:0] op, input logic [15:0] off);
`ifdef BRANCH_PREDICT_EN
      if (op == 3'd6) return 1'b1;
      if (op == 3'd7) return 1'b0;
      return off[15];
`else
      return (op != op) && (off != off);
`endif
   endfunction

   task automatic idle(input int n, input bit rand_stall);
      for (int i = 0; i < n; i++) begin
         bif.br_valid = 1'b0;
         fetch_stall  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         exp_pc = adv(fetch_stall);
         check32("idle_pc", pc, exp_pc);
         check1("idle_flush", flush, 1'b0);
         check1("idle_done", bif.br_done, 1'b0);
         check1("idle_ready", bif.br_ready, 1'b1);
      end
   endtask

   // One request through accept, EVAL and RESOLVE with per-edge stall values.
   task automatic run_branch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [15:0] off, input logic [31:0] bpc,
                             input logic [2:0] stalls, input bit hold);
      logic        taken;
      logic        pred;
      logic        mis;
      logic [31:0] tgt;
      taken = ref_taken(op, a, b);
      pred  = ref_pred(op, off);
      mis   = taken != pred;
      tgt   = bpc + 32'd4 + 32'(int'($signed(off)) * 4);

      check1("ready_before_accept", bif.br_ready, 1'b1);
      bif.br_valid = 1'b1;
      bif.br_op    = op;
      bif.rs       = a;
      bif.rt       = b;
      bif.offset   = off;
      bif.br_pc    = bpc;
      fetch_stall  = stalls[0];
      tick();
      exp_pc = pred ? tgt : adv(stalls[0]);
      check32("accept_pc", pc, exp_pc);
      check1("eval_ready", bif.br_ready, 1'b0);
      check1("eval_done", bif.br_done, 1'b0);
      check1("eval_flush", flush, 1'b0);

      bif.br_valid = hold;
      if (!hold) begin
         bif.br_op  = 3'($urandom_range(0, 7));
         bif.rs     = $urandom;
         bif.rt     = $urandom;
         bif.offset = 16'($urandom);
         bif.br_pc  = $urandom;
      end
      fetch_stall = stalls[1];
      tick();
      exp_pc = mis ? (taken ? tgt : bpc + 32'd4) : adv(stalls[1]);
      check32("resolve_pc", pc, exp_pc);
      check1("resolve_done", bif.br_done, 1'b1);
      check1("resolve_taken", bif.br_taken, taken);
      check1("resolve_flush", flush, mis);
      check1("resolve_ready", bif.br_ready, 1'b0);

      fetch_stall = stalls[2];
      tick();
      exp_pc = adv(stalls[2]);
      check32("after_pc", pc, exp_pc);
      check1("after_done", bif.br_done, 1'b0);
      check1("after_flush", flush, 1'b0);
      check1("after_ready", bif.br_ready, 1'b1);
      bif.br_valid = 1'b0;
      fetch_stall  = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] a;
      logic [31:0] b;

      bif.br_valid = 1'b0;
      bif.br_op    = '0;
      bif.rs       = '0;
      bif.rt       = '0;
      bif.offset   = '0;
      bif.br_pc    = '0;

      // Reset values.
      tick();
      tick();
      reset = 1'b0;
      exp_pc = RST_PC;
      check32("reset_pc", pc, RST_PC);
      check1("reset_ready", bif.br_ready, 1'b1);
      check1("reset_flush", flush, 1'b0);
      check1("reset_done", bif.br_done, 1'b0);
      check1("reset_taken", bif.br_taken, 1'b0);

      // Sequential advance 104..110.
      idle(4, 1'b0);
      check32("seq_pc_110", pc, 32'h0000_0110);
      idle(3, 1'b1);

      // BGTE -3 >= -5, forward: taken, flush, pc 214.
      run_branch(3'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 16'd4, 32'h200, 3'b000, 1'b0);
      idle(1, 1'b0);

      // BLTU FFFFFFFF < 1 is false; BLT -1 < 1 is true.
      run_branch(3'd4, 32'hFFFF_FFFF, 32'h1, 16'd8, 32'h240, 3'b000, 1'b0);
      run_branch(3'd2, 32'hFFFF_FFFF, 32'h1, 16'd8, 32'h240, 3'b000, 1'b0);

      // BNE equal operands, backward offset.
      run_branch(3'd1, 32'd7, 32'd7, 16'hFFFE, 32'h300, 3'b000, 1'b0);
      check32("bne_back_pc", pc, exp_pc);

      // J wrapping to zero, request held high while busy.
      run_branch(3'd6, 32'h0, 32'h0, 16'd1, 32'hFFFF_FFF8, 3'b000, 1'b1);
      // Back-to-back accept right as br_ready returns.
      run_branch(3'd0, 32'h55, 32'h55, 16'd2, 32'h1000, 3'b000, 1'b0);

      // Stall held through EVAL and RESOLVE; redirect still applies.
      run_branch(3'd5, 32'h10, 32'h10, 16'd3, 32'h2000, 3'b111, 1'b0);
      run_branch(3'd7, 32'h1, 32'h1, 16'hFFF0, 32'h2100, 3'b110, 1'b0);

      // Randomized requests.
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         r = $urandom;
         run_branch(3'($urandom_range(0, 7)), a, b, 16'($urandom), r & 32'hFFFF_FFFC,
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2), 1'b1);
      end

      // Reset during EVAL aborts the request.
      bif.br_valid = 1'b1;
      bif.br_op    = 3'd0;
      bif.rs       = 32'd5;
      bif.rt       = 32'd5;
      bif.offset   = 16'd4;
      bif.br_pc    = 32'h400;
      tick();
      check1("abort_eval_ready", bif.br_ready, 1'b0);
      reset = 1'b1;
      #1;
      check32("abort_pc", pc, RST_PC);
      check1("abort_ready", bif.br_ready, 1'b1);
      check1("abort_done", bif.br_done, 1'b0);
      check1("abort_flush", flush, 1'b0);
      bif.br_valid = 1'b0;
      tick();
      check1("abort_hold_done", bif.br_done, 1'b0);
      check1("abort_hold_flush", flush, 1'b0);
      reset = 1'b0;
      exp_pc = RST_PC;
      idle(3, 1'b0);
      check32("post_abort_pc", pc, RST_PC + 32'd12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Next-PC controller for the conditional branch datapath. It owns the program counter and accepts one branch or jump request at a time over a valid/ready handshake. It resolves the request against captured operands in a fixed three-state sequence and redirects the PC with a one-cycle flush pulse when the fetched path was wrong. It sits between decode, which issues requests, and instruction fetch, which consumes `pc` and `flush`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `fetch_stall`  in  1  holds PC sequential advance.
- `br_valid`  in  1  branch request valid.
- `br_ready`  out  1  sequencer can accept a request.
- `br_op`  in  3  op: 000 BEQ, 001 BNE, 010 BLT signed, 011 BGTE signed (rs>=rt), 100 BLTU, 101 BGEU, 110 J (always taken), 111 reserved.
- `rs`  in  32  first operand.
- `rt`  in  32  second operand.
- `offset`  in  16  signed word offset.
- `br_pc`  in  32  address of the branch instruction.
- `pc`  out  32  current fetch PC.
- `flush`  out  1  one-cycle pulse: discard instructions fetched after the branch.
- `br_done`  out  1  one-cycle pulse: request resolved.
- `br_taken`  out  1  resolution result, valid while `br_done`=1.

## Operation
States: RUN, EVAL, RESOLVE.

RUN:
- `br_ready`=1.
- `pc` <= `pc`+4 each cycle unless `fetch_stall`=1.
- Handshake fires on `br_valid`&&`br_ready`. On that edge, capture `br_op`, `rs`, `rt`, `br_pc` and `offset`, compute the predicted direction `pred`, and go to EVAL.

EVAL:
- `br_ready`=0.
- Evaluate the condition combinationally on the captured operands. Signed ops compare two's complement; unsigned ops compare magnitude. Op 111 is never taken.
- `pc` keeps advancing per `fetch_stall`.
- Go to RESOLVE.

RESOLVE:
- `br_ready`=0, `br_done`=1, `br_taken`=condition result.
- `flush`=1 iff result != `pred`.
- On mispredict, the PC was loaded on the EVAL->RESOLVE edge with `target` if taken, otherwise `br_pc`+4. This load overrides `fetch_stall`.
- Otherwise `pc` advances per `fetch_stall`.
- Go to RUN.

Arithmetic:
- `target` = `br_pc` + 4 + (sign-extend-32(`offset`) << 2).
- All PC arithmetic is modulo 2^32; wrap past 32'hFFFF_FFFC is legal and silent.

Requests while busy:
- `br_valid` in EVAL or RESOLVE is not accepted. Decode must hold the request stable until `br_ready`=1.

## Timing
- Request accepted at edge T. EVAL is cycle T..T+1. RESOLVE is cycle T+1..T+2; `br_done`, `br_taken` and `flush` are high only in this cycle.
- A redirected `pc` is visible in the same cycle as `flush`.
- `br_ready` returns high in the cycle after RESOLVE, so throughput is one request per 3 cycles.
- Output reset values: `pc`=`RESET_PC`, `br_ready`=1 (state RUN), `flush`=0, `br_done`=0, `br_taken`=0.
- Reset mid-EVAL or mid-RESOLVE aborts the request; no `br_done` or `flush` is produced.
- `fetch_stall` held through EVAL and RESOLVE does not delay resolution; a redirect still takes effect.

## Configuration
- `BRANCH_PREDICT_EN` defined (static backward-taken/forward-not-taken prediction):
  - `pred`=1 for J, and for conditional ops with `offset`[15]=1.
  - When `pred`=1, `pc` <= `target` on the accept edge, overriding `fetch_stall`.
  - A mispredicted not-taken result redirects to `br_pc`+4 in RESOLVE.
- Undefined: `pred`=0 for every op. `pc` is never modified at accept, and every taken branch, including J, flushes.

## Test plan
- Reset with `RESET_PC`=32'h100, then 4 cycles with no stall -> `pc` = 100,104,108,10C,110; `flush`=0.
- BGTE with `rs`=-3, `rt`=-5, `br_pc`=32'h200, `offset`=4 -> RESOLVE: `br_taken`=1, `flush`=1, `pc`=32'h214. With the macro, `pred`=0 gives the same result.
- BLTU with `rs`=32'hFFFF_FFFF, `rt`=1 -> `br_taken`=0, `flush`=0, `pc` continues sequentially. BLT with the same operands -> taken.
- With the macro, BNE with `rs`=`rt`=7, `br_pc`=32'h300, `offset`=16'hFFFE -> at accept, `pc`=32'h2FC; in RESOLVE, `flush`=1 and `pc`=32'h304.
- `br_pc`=32'hFFFF_FFF8, J, `offset`=1 -> `pc`=32'h0000_0000 (wrap). `br_valid` held high in EVAL is not accepted until `br_ready`=1.
- Reset asserted in the EVAL cycle -> `pc`=`RESET_PC`, no `br_done` or `flush` pulse, and `br_ready`=1 after release.
